// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared DDR read-path parameters and the order-FIFO entry type.
// Owner field is sized for the largest supported requester count (8).
package GLOBAL_PARAM;

  localparam int DDR_W       = 32;
  localparam int DDR_ADDR_W  = 32;
  localparam int BURST_W     = 4;
  localparam int REQ_NUM_MAX = 8;

  // Bits needed to encode n distinct values (minimum 1).
  function automatic int bw(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int OWNER_W = bw(REQ_NUM_MAX);

  typedef struct packed {
    logic [OWNER_W-1:0] owner;
    logic [BURST_W-1:0] size;
  } rd_order_t;

endpackage

// File: rtl/ddr_rd_arbiter_order_fifo.sv
// Synchronous order FIFO: one entry per granted burst, popped when its last beat returns.
// Full/empty come from the registered count, so a same-cycle pop never frees room for a push.
module rd_order_fifo
  import GLOBAL_PARAM::bw;
#(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = bw(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin DDR read-address arbiter with in-order data return steered by an order FIFO.
// The data router is purely combinational from ddr_valid; owner back-pressure stalls the channel.
module ddr_rd_arbiter
  import GLOBAL_PARAM::bw;
  import GLOBAL_PARAM::rd_order_t;
  import GLOBAL_PARAM::OWNER_W;
#(
  parameter int REQ_NUM     = 4,
  parameter int ORDER_DEPTH = 16,
  parameter int DDR_ADDR_W  = GLOBAL_PARAM::DDR_ADDR_W,
  parameter int BURST_W     = GLOBAL_PARAM::BURST_W,
  parameter int DDR_W       = GLOBAL_PARAM::DDR_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_NUM-1:0][DDR_ADDR_W-1:0]  req_addr,
  input  logic [REQ_NUM-1:0][BURST_W-1:0]     req_size,
  input  logic [REQ_NUM-1:0]                  req_valid,
  output logic [REQ_NUM-1:0]                  req_ready,
  output logic [DDR_ADDR_W-1:0]               ddr_addr,
  output logic [BURST_W-1:0]                  ddr_size,
  output logic                                ddr_addr_valid,
  input  logic                                ddr_addr_ready,
  input  logic [DDR_W-1:0]                    ddr_data,
  input  logic                                ddr_valid,
  output logic                                ddr_ready,
  output logic [DDR_W-1:0]                    rsp_data,
  output logic [REQ_NUM-1:0]                  rsp_valid,
  input  logic [REQ_NUM-1:0]                  rsp_ready,
  output logic [bw(ORDER_DEPTH+1)-1:0]        outstanding,
  output logic                                err_orphan
);

  localparam int GW = bw(REQ_NUM);

  logic [GW-1:0]         last_q, win, cand;
  logic                  found, grant, grant_ok, slot_free;
  int                    arb_idx;
  logic [DDR_ADDR_W-1:0] addr_q;
  logic [BURST_W-1:0]    size_q;
  logic                  avalid_q;
  logic [BURST_W-1:0]    cnt_q, cnt_d;
  logic                  err_q;
  logic                  fifo_full, fifo_empty, pop, accept;
  rd_order_t             push_entry, head;
  logic [$bits(rd_order_t)-1:0] fifo_dout;

  assign slot_free = !avalid_q || ddr_addr_ready;
  assign grant_ok  = slot_free && !fifo_full;

  always_comb begin
    found   = 1'b0;
    win     = '0;
    arb_idx = 0;
    cand    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      arb_idx = int'(last_q) + 1 + i;
      if (arb_idx >= REQ_NUM) arb_idx = arb_idx - REQ_NUM;
      cand = GW'(arb_idx);
      if (!found && req_valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // rst gates the combinational grant so req_ready is 0 throughout reset.
  assign grant     = found && grant_ok && !rst;
  assign req_ready = grant ? (REQ_NUM'(1) << win) : '0;

  assign push_entry.owner = OWNER_W'(win);
  assign push_entry.size  = req_size[win];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      size_q   <= '0;
      avalid_q <= 1'b0;
      last_q   <= GW'(REQ_NUM - 1);
    end else if (grant) begin
      addr_q   <= req_addr[win];
      size_q   <= req_size[win];
      avalid_q <= 1'b1;
      last_q   <= win;
    end else if (ddr_addr_ready) begin
      avalid_q <= 1'b0;
    end
  end

  assign ddr_addr       = addr_q;
  assign ddr_size       = size_q;
  assign ddr_addr_valid = avalid_q;

  rd_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .W     ($bits(rd_order_t))
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  assign head     = rd_order_t'(fifo_dout);
  assign rsp_data = ddr_data;

  always_comb begin
    ddr_ready = 1'b0;
    rsp_valid = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (head.owner == OWNER_W'(i)) begin
        rsp_valid[i] = !fifo_empty && ddr_valid;
        ddr_ready    = !fifo_empty && rsp_ready[i];
      end
    end
  end

  assign accept = ddr_valid && ddr_ready;
  assign pop    = accept && (cnt_q == head.size);

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = pop ? '0 : cnt_q + BURST_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (ddr_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign err_orphan = err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: grants, round-robin order, back-pressure, FIFO full, reset.
module tb_ddr_rd_arbiter;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0][31:0]  req_addr;
  logic [3:0][3:0]   req_size;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [31:0]       ddr_addr;
  logic [3:0]        ddr_size;
  logic              ddr_addr_valid;
  logic              ddr_addr_ready;
  logic [31:0]       ddr_data;
  logic              ddr_valid;
  logic              ddr_ready;
  logic [31:0]       rsp_data;
  logic [3:0]        rsp_valid;
  logic [3:0]        rsp_ready;
  logic [4:0]        outstanding;
  logic              err_orphan;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr_rd_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .ddr_addr       (ddr_addr),
    .ddr_size       (ddr_size),
    .ddr_addr_valid (ddr_addr_valid),
    .ddr_addr_ready (ddr_addr_ready),
    .ddr_data       (ddr_data),
    .ddr_valid      (ddr_valid),
    .ddr_ready      (ddr_ready),
    .rsp_data       (rsp_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .outstanding    (outstanding),
    .err_orphan     (err_orphan)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_addr       = '0;
    req_size       = '0;
    req_valid      = '0;
    ddr_addr_ready = 1'b1;
    ddr_data       = '0;
    ddr_valid      = 1'b0;
    rsp_ready      = '1;
    tick();
    rst = 1'b0;
  endtask

  int exp_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    do_reset();

    // Reset state
    #1;
    check("rst_avalid", ddr_addr_valid, 0);
    check("rst_addr", ddr_addr, 0);
    check("rst_outst", outstanding, 0);
    check("rst_err", err_orphan, 0);
    check("rst_ddr_ready", ddr_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);

    // 1: single requester, size 3
    tick();
    req_addr[0] = 32'h1000; req_size[0] = 4'd3; req_valid = 4'b0001;
    #1 check("t1_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    check("t1_addr", ddr_addr, 32'h1000);
    check("t1_size", ddr_size, 3);
    check("t1_avalid", ddr_addr_valid, 1);
    check("t1_outst1", outstanding, 1);
    tick();
    check("t1_avalid_clr", ddr_addr_valid, 0);
    for (int b = 0; b < 4; b++) begin
      ddr_valid = 1'b1; ddr_data = 32'hD0 + b;
      #1;
      check("t1_rsp_valid", rsp_valid, 4'b0001);
      check("t1_rsp_data", rsp_data, 32'hD0 + b);
      check("t1_ddr_ready", ddr_ready, 1);
      tick();
    end
    ddr_valid = 1'b0;
    #1 check("t1_outst0", outstanding, 0);

    // 2: all requesters, round-robin
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i] = 32'h100 * (i + 1);
    req_size[0] = 4'd0; req_size[1] = 4'd1; req_size[2] = 4'd0; req_size[3] = 4'd1;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 check("t2_grant", req_ready, 4'b0001 << exp_order[k]);
      tick();
      check("t2_addr", ddr_addr, 32'h100 * (exp_order[k] + 1));
    end
    req_valid = '0;
    #1 check("t2_outst6", outstanding, 6);
    tick();
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b <= ((exp_order[k] % 2 == 1) ? 1 : 0); b++) begin
        ddr_valid = 1'b1; ddr_data = 32'hE000 + k * 16 + b;
        #1 check("t2_rsp_owner", rsp_valid, 4'b0001 << exp_order[k]);
        tick();
      end
    end
    ddr_valid = 1'b0;
    #1 check("t2_outst0", outstanding, 0);

    // 3: owner back-pressure on requester 2
    do_reset();
    req_addr[0] = 32'h2000; req_size[0] = 4'd0;
    req_addr[2] = 32'h3000; req_size[2] = 4'd1;
    req_valid = 4'b0001;
    #1 check("t3_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0100;
    #1 check("t3_grant2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    ddr_valid = 1'b1; ddr_data = 32'hA0;
    #1;
    check("t3_addr", ddr_addr, 32'h3000);
    check("t3_size", ddr_size, 1);
    check("t3_outst2", outstanding, 2);
    check("t3_rsp0", rsp_valid, 4'b0001);
    tick();
    rsp_ready = 4'b1011; ddr_data = 32'hB0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_stall_ready", ddr_ready, 0);
      check("t3_stall_rsp", rsp_valid, 4'b0100);
      check("t3_stall_outst", outstanding, 1);
      tick();
    end
    rsp_ready = '1;
    #1;
    check("t3_b0_ready", ddr_ready, 1);
    check("t3_b0_data", rsp_data, 32'hB0);
    tick();
    ddr_data = 32'hB1;
    #1 check("t3_b1_rsp", rsp_valid, 4'b0100);
    tick();
    ddr_valid = 1'b0;
    #1 check("t3_outst0", outstanding, 0);

    // 4: fill the order FIFO
    do_reset();
    req_addr[0] = 32'h4000; req_size[0] = 4'd0; req_valid = 4'b0001;
    for (int g = 0; g < 16; g++) tick();
    #1;
    check("t4_outst16", outstanding, 16);
    check("t4_full_ready", req_ready, 0);
    tick();
    ddr_valid = 1'b1; ddr_data = 32'hC0;
    #1;
    check("t4_pop_ready", ddr_ready, 1);
    check("t4_no_same_cycle", req_ready, 0);
    tick();
    ddr_valid = 1'b0;
    #1;
    check("t4_outst15", outstanding, 15);
    check("t4_regrant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1 check("t4_outst16b", outstanding, 16);

    // 5: address stall
    do_reset();
    ddr_addr_ready = 1'b0;
    req_addr[1] = 32'h5000; req_size[1] = 4'd2;
    req_addr[3] = 32'h7000; req_size[3] = 4'd5;
    req_valid = 4'b0010;
    #1 check("t5_grant1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t5_hold_ready", req_ready, 0);
      check("t5_hold_addr", ddr_addr, 32'h5000);
      check("t5_hold_size", ddr_size, 2);
      check("t5_hold_valid", ddr_addr_valid, 1);
      tick();
    end
    ddr_addr_ready = 1'b1;
    #1 check("t5_release_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    #1;
    check("t5_addr3", ddr_addr, 32'h7000);
    check("t5_size3", ddr_size, 5);
    check("t5_outst2", outstanding, 2);

    // 6: reset mid-burst, then an orphan beat
    do_reset();
    req_addr[0] = 32'h6000; req_size[0] = 4'd3; req_valid = 4'b0001;
    tick();
    req_valid = '0;
    ddr_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      ddr_data = 32'hF0 + b;
      tick();
    end
    ddr_data = 32'hF2; req_addr[1] = 32'h6100; req_valid = 4'b0010;
    #1;
    check("t6_pre_outst", outstanding, 1);
    check("t6_pre_rsp", rsp_valid, 4'b0001);
    rst = 1'b1;
    #1;
    check("t6_rst_avalid", ddr_addr_valid, 0);
    check("t6_rst_addr", ddr_addr, 0);
    check("t6_rst_req_ready", req_ready, 0);
    check("t6_rst_rsp", rsp_valid, 0);
    check("t6_rst_ddr_ready", ddr_ready, 0);
    check("t6_rst_outst", outstanding, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    check("t6_orphan_ready", ddr_ready, 0);
    check("t6_orphan_rsp", rsp_valid, 0);
    check("t6_err_before", err_orphan, 0);
    tick();
    ddr_valid = 1'b0;
    #1 check("t6_err_set", err_orphan, 1);
    tick();
    check("t6_err_sticky", err_orphan, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_rd_arbiter.md
Name: ddr_rd_arbiter

Overview:
Shares one DDR read port (address channel plus data channel) among REQ_NUM requesters, such as the ddr_addr_gen instances and the buffer loaders. Address-channel grants are round-robin. Each grant records {owner, beat count} in an order FIFO. Returned read data is steered back to the owning requester burst by burst, in issue order. The block sits between the ddr2pe request side and the single memory-controller read interface.

Parameters:
REQ_NUM, 4, number of requesters (2..8)
ORDER_DEPTH, 16, outstanding-burst capacity of the order FIFO (power of 2)
DDR_ADDR_W, GLOBAL_PARAM::DDR_ADDR_W, address width
BURST_W, GLOBAL_PARAM::BURST_W, burst size width
DDR_W, GLOBAL_PARAM::DDR_W, data beat width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_addr  in  REQ_NUM x DDR_ADDR_W  per-requester burst start address
req_size  in  REQ_NUM x BURST_W  per-requester burst size; beats = size+1
req_valid  in  REQ_NUM  request valid
req_ready  out  REQ_NUM  request accepted (one-hot or zero)
ddr_addr  out  DDR_ADDR_W  address to controller
ddr_size  out  BURST_W  size to controller
ddr_addr_valid  out  1  address valid
ddr_addr_ready  in  1  controller accepts address
ddr_data  in  DDR_W  read data beat
ddr_valid  in  1  beat valid
ddr_ready  out  1  beat accepted
rsp_data  out  DDR_W  ddr_data broadcast to all requesters
rsp_valid  out  REQ_NUM  beat valid for owner only
rsp_ready  in  REQ_NUM  requester accepts beat
outstanding  out  bw(ORDER_DEPTH+1)  bursts granted and not yet fully returned
err_orphan  out  1  sticky; set when ddr_valid=1 while order FIFO empty

Behaviour:
- Reset (async, immediate): ddr_addr_valid=0; ddr_addr=0; ddr_size=0; req_ready=0; rsp_valid=0; ddr_ready=0; outstanding=0; err_orphan=0; order FIFO empty; last_grant=REQ_NUM-1, so requester 0 wins first. Reset mid-burst discards all outstanding order entries. Beats arriving after reset are orphans.
- Address slot is a single output register.
- slot_free = !ddr_addr_valid || ddr_addr_ready.
- grant_ok = slot_free && !fifo_full.
- Arbitration (combinational): scan req_valid starting at last_grant+1 with wrap-around; the first set bit wins.
- req_ready[w]=1 only for the winner and only when grant_ok.
- Grant cycle N (req_valid[w] && req_ready[w]):
  - ddr_addr/ddr_size load from requester w; ddr_addr_valid=1 from cycle N+1.
  - Push {w, req_size[w]} into the order FIFO.
  - last_grant<=w.
- Without a new grant, ddr_addr_valid clears on the address handshake.
- Address outputs stay stable while ddr_addr_valid && !ddr_addr_ready.
- Back-to-back grants give one address per cycle when ddr_addr_ready=1.
- Data router is combinational from ddr_valid to outputs, with no added latency. Head entry is {own, sz}; beat counter cnt resets to 0.
  - ddr_ready = !fifo_empty && rsp_ready[own].
  - rsp_valid[own] = !fifo_empty && ddr_valid; all other rsp_valid bits are 0.
  - rsp_data = ddr_data.
  - On each accepted beat (ddr_valid && ddr_ready): if cnt==sz, pop and set cnt<=0; else cnt<=cnt+1.
  - Owner back-pressure stalls the whole data channel (in-order return, no reordering).
- FIFO empty with ddr_valid=1: ddr_ready=0, rsp_valid=0, err_orphan<=1. err_orphan clears only on reset.
- FIFO full: no grants. A pop in the same cycle does not enable a push; full is evaluated on registered state.
- Simultaneous push and pop: both take effect; outstanding is unchanged.
- outstanding = FIFO occupancy, incremented on push and decremented on pop.
- A burst of size 0 is a single beat; push and pop may involve the same entry in consecutive cycles.

Decomposition:
- Shared package GLOBAL_PARAM: DDR_W, DDR_ADDR_W, BURST_W, bw(). Add the order-entry struct typedef rd_order_t {owner[bw(REQ_NUM)], size[BURST_W]}.
- Sub-module rd_order_fifo: synchronous FIFO, depth ORDER_DEPTH, width $bits(rd_order_t), with count output. It shares clk/rst (async active-high).
- The arbiter and router logic stay in the top level.

Test Plan:
1. Requester 0 only: addr=0x1000, size=3, all ready=1 -> ddr_addr=0x1000, ddr_size=3 valid the cycle after the grant; 4 returned beats D0..D3 appear on rsp_valid[0] only; outstanding goes 1 -> 0 after D3.
2. All four req_valid held high, ddr_addr_ready=1 -> grant order 0,1,2,3,0,1, one per cycle; data bursts return to owners in that order.
3. Second burst owned by requester 2 (size=1) with rsp_ready[2]=0 for 5 cycles while ddr_valid=1 -> ddr_ready=0 for those cycles; no beat lost; beats delivered once rsp_ready[2]=1.
4. 16 grants issued with no data returned -> outstanding=16; all req_ready=0. One single-beat burst returns -> next cycle one grant allowed.
5. ddr_addr_ready=0 for 4 cycles after a grant -> ddr_addr/ddr_size stable; req_ready=0 throughout; handshake completes on release.
6. Assert rst mid-burst (beat 2 of 4) -> all outputs 0 in the same cycle, outstanding=0; a beat arriving after reset release -> ddr_ready=0, err_orphan=1.
